burst_memory: RTL and testbench

Parametrised single-port word memory with a valid/ready request handshake, read and write bursts of 1 to MAX_BURST beats with auto-incrementing address, and a per-transaction status response. It replaces the fixed 8-bit × 256-word memory unit as the data store behind the CPU load/store path. It adds:

- back-to-back transactions with no re-enable;
- streamed burst data;
- explicit range checking, with no access performed on error.

---
 rtl/burst_memory.sv | 139 +++++++++++++
 tb/tb_burst_memory.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_memory.sv
// Single-port word memory behind a valid/ready request handshake, serving
// auto-incrementing read/write bursts and returning a per-transaction status.
module burst_memory #(
    parameter int WORDSIZE   = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int LEN_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [WORDSIZE-1:0]   wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [WORDSIZE-1:0]   rd_data,
    output logic                  rd_valid,
    output logic                  resp_valid,
    output logic [1:0]            resp_status
);

    localparam int                CHK_W     = ADDR_WIDTH + 1;
    localparam logic [CHK_W-1:0]  DEPTH_EXT = CHK_W'(DEPTH);
    localparam logic [1:0]        ST_OK     = 2'b00;
    localparam logic [1:0]        ST_RANGE  = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_cnt_q, addr_cnt_d;
    logic [LEN_WIDTH-1:0]    beat_cnt_q, beat_cnt_d;
    logic [1:0]              status_q, status_d;
    logic                    rd_valid_q, rd_valid_d;
    logic [WORDSIZE-1:0]     rd_data_q;
    logic                    mem_we;
    logic                    mem_re;
    logic [CHK_W-1:0]        end_addr;
    logic                    range_err;

    logic [WORDSIZE-1:0]     mem [DEPTH] = '{default: '0};

    // Last beat address computed one bit wider so a wrapping burst is caught.
    assign end_addr  = {1'b0, req_addr} + CHK_W'(req_len);
    assign range_err = (end_addr >= DEPTH_EXT);

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        beat_cnt_d = beat_cnt_q;
        status_d   = status_q;
        rd_valid_d = rd_valid_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_cnt_d = req_addr;
                    beat_cnt_d = req_len;
                    if (range_err) begin
                        status_d = ST_RANGE;
                        state_d  = S_RESP;
                    end else begin
                        status_d = ST_OK;
                        state_d  = req_op ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    mem_we     = 1'b1;
                    addr_cnt_d = addr_cnt_q + 1'b1;
                    beat_cnt_d = beat_cnt_q - 1'b1;
                    if (beat_cnt_q == '0) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_READ: begin
                mem_re     = 1'b1;
                rd_valid_d = 1'b1;
                addr_cnt_d = addr_cnt_q + 1'b1;
                beat_cnt_d = beat_cnt_q - 1'b1;
                if (beat_cnt_q == '0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rd_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_cnt_q <= '0;
            beat_cnt_q <= '0;
            status_q   <= ST_OK;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            status_q   <= status_d;
            rd_valid_q <= rd_valid_d;
            if (mem_re) begin
                rd_data_q <= mem[addr_cnt_q];
            end
        end
    end

    // Reset blocks the write so an interrupted burst stops at the last taken beat.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[addr_cnt_q] <= wr_data;
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign wr_ready    = (state_q == S_WRITE);
    assign resp_valid  = (state_q == S_RESP);
    assign resp_status = status_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_burst_memory.sv
// Directed bench for burst_memory: a default instance plus a DEPTH=200
// instance sharing the same stimulus for the non-power-of-two range limit.
module tb_burst_memory;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_op;
    logic [7:0] req_addr;
    logic [1:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid;

    logic       req_ready, wr_ready, rd_valid, resp_valid;
    logic [7:0] rd_data;
    logic [1:0] resp_status;

    logic       req_ready2, wr_ready2, rd_valid2, resp_valid2;
    logic [7:0] rd_data2;
    logic [1:0] resp_status2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    burst_memory dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .resp_valid (resp_valid),
        .resp_status(resp_status)
    );

    burst_memory #(.DEPTH(200)) dut200 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready2),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready2),
        .rd_data    (rd_data2),
        .rd_valid   (rd_valid2),
        .resp_valid (resp_valid2),
        .resp_status(resp_status2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst with wr_valid held high; data byte i is beat i.
    task automatic write_burst(input string tag, input logic [7:0] addr,
                               input logic [1:0] len, input logic [31:0] data);
        check({tag, " req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_op = 1'b1; req_addr = addr; req_len = len;
        wr_valid  = 1'b1; wr_data = data[7:0];
        tick();
        req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            check({tag, " wr_ready"}, wr_ready, 1);
            check({tag, " no early resp"}, resp_valid, 0);
            wr_data = data[8*i +: 8];
            tick();
        end
        wr_valid = 1'b0;
        check({tag, " resp_valid"}, resp_valid, 1);
        check({tag, " resp_status"}, resp_status, 2'b00);
        check({tag, " wr_ready after"}, wr_ready, 0);
        tick();
        check({tag, " back to idle"}, req_ready, 1);
        $display("[TB] write addr=0x%02h len=%0d data=0x%08h done", addr, len, data);
    endtask

    task automatic read_burst(input string tag, input logic [7:0] addr,
                              input logic [1:0] len, input logic [31:0] exp);
        check({tag, " req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_op = 1'b0; req_addr = addr; req_len = len;
        tick();
        req_valid = 1'b0;
        check({tag, " no data yet"}, rd_valid, 0);
        for (int i = 0; i <= int'(len); i++) begin
            tick();
            check({tag, " rd_valid"}, rd_valid, 1);
            check({tag, " rd_data"}, rd_data, exp[8*i +: 8]);
            check({tag, " resp_valid"}, resp_valid, (i == int'(len)) ? 1 : 0);
            check({tag, " req_ready busy"}, req_ready, 0);
        end
        check({tag, " resp_status"}, resp_status, 2'b00);
        tick();
        check({tag, " rd_valid drop"}, rd_valid, 0);
        check({tag, " back to idle"}, req_ready, 1);
        $display("[TB] read addr=0x%02h len=%0d expect=0x%08h done", addr, len, exp);
    endtask

    task automatic error_req(input string tag, input logic [7:0] addr,
                             input logic [1:0] len, input logic op);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_len = len;
        wr_valid  = op; wr_data = 8'hEE;
        tick();
        req_valid = 1'b0;
        check({tag, " resp_valid"}, resp_valid, 1);
        check({tag, " resp_status"}, resp_status, 2'b01);
        check({tag, " wr_ready low"}, wr_ready, 0);
        check({tag, " rd_valid low"}, rd_valid, 0);
        wr_valid = 1'b0;
        tick();
        check({tag, " idle"}, req_ready, 1);
        check({tag, " resp drop"}, resp_valid, 0);
        check({tag, " rd_valid still low"}, rd_valid, 0);
        $display("[TB] error addr=0x%02h len=%0d op=%0d done", addr, len, op);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_addr = '0;
        req_len = '0; wr_data = '0; wr_valid = 1'b0;
        tick();
        tick();
        check("reset req_ready", req_ready, 1);
        check("reset wr_ready", wr_ready, 0);
        check("reset resp_valid", resp_valid, 0);
        check("reset rd_valid", rd_valid, 0);
        check("reset rd_data", rd_data, 8'h00);
        check("reset resp_status", resp_status, 2'b00);
        reset = 1'b0;
        tick();
        $display("[TB] reset done");

        // Single-beat write and read
        write_burst("single wr", 8'h10, 2'd0, 32'h000000A5);
        read_burst("single rd", 8'h10, 2'd0, 32'h000000A5);

        // Maximum burst at the top of memory
        write_burst("max wr", 8'hFC, 2'd3, 32'h04030201);
        read_burst("max rd", 8'hFC, 2'd3, 32'h04030201);

        // Range errors, then confirm the top words were not disturbed
        error_req("err wr FE+3", 8'hFE, 2'd3, 1'b1);
        error_req("err rd FE+3", 8'hFE, 2'd3, 1'b0);
        error_req("err rd FD+3", 8'hFD, 2'd3, 1'b0);
        read_burst("after err rd", 8'hFE, 2'd1, 32'h00000403);

        // DEPTH=200 instance: 199 is the last legal word, 200 is rejected
        req_valid = 1'b1; req_op = 1'b0; req_addr = 8'd199; req_len = 2'd0;
        tick();
        req_valid = 1'b0;
        check("d200 199 no resp yet", resp_valid2, 0);
        tick();
        check("d200 199 rd_valid", rd_valid2, 1);
        check("d200 199 rd_data", rd_data2, 8'h00);
        check("d200 199 status", resp_status2, 2'b00);
        tick();
        check("d200 199 idle", req_ready2, 1);
        req_valid = 1'b1; req_op = 1'b0; req_addr = 8'd200; req_len = 2'd0;
        tick();
        req_valid = 1'b0;
        check("d200 200 resp_valid", resp_valid2, 1);
        check("d200 200 status", resp_status2, 2'b01);
        check("d200 200 rd_valid", rd_valid2, 0);
        check("d256 200 accepted", resp_valid, 0);
        tick();
        check("d200 200 idle", req_ready2, 1);
        check("d200 200 no data", rd_valid2, 0);
        check("d256 200 rd_data", rd_data, 8'h00);
        tick();
        $display("[TB] depth-200 boundary done");

        // Write with three stall cycles between the two beats
        req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h30; req_len = 2'd1;
        wr_valid = 1'b1; wr_data = 8'h5A;
        tick();
        req_valid = 1'b0;
        tick();
        wr_valid = 1'b0; wr_data = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check("stall wr_ready", wr_ready, 1);
            check("stall no resp", resp_valid, 0);
            tick();
        end
        wr_valid = 1'b1; wr_data = 8'h6B;
        tick();
        wr_valid = 1'b0;
        check("stall resp_valid", resp_valid, 1);
        check("stall resp_status", resp_status, 2'b00);
        tick();
        check("stall idle", req_ready, 1);
        $display("[TB] stalled write done");
        read_burst("stall rd", 8'h30, 2'd1, 32'h00006B5A);

        // Request held during a read burst is taken only once idle again
        write_burst("ign wr a", 8'h40, 2'd1, 32'h00008877);
        write_burst("ign wr b", 8'h50, 2'd0, 32'h00000099);
        req_valid = 1'b1; req_op = 1'b0; req_addr = 8'h40; req_len = 2'd1;
        tick();
        req_addr = 8'h50; req_len = 2'd0;
        tick();
        check("ign beat0 data", rd_data, 8'h77);
        check("ign beat0 busy", req_ready, 0);
        tick();
        check("ign beat1 data", rd_data, 8'h88);
        check("ign beat1 resp", resp_valid, 1);
        tick();
        check("ign idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check("ign second accepted", req_ready, 0);
        check("ign second no data", rd_valid, 0);
        tick();
        check("ign second rd_valid", rd_valid, 1);
        check("ign second rd_data", rd_data, 8'h99);
        check("ign second resp", resp_valid, 1);
        tick();
        check("ign second idle", req_ready, 1);
        $display("[TB] ignored request done");

        // Reset after the first beat of a four-beat write
        req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h20; req_len = 2'd3;
        wr_valid = 1'b1; wr_data = 8'h11;
        tick();
        req_valid = 1'b0;
        tick();
        reset = 1'b1; wr_data = 8'h22;
        tick();
        reset = 1'b0; wr_valid = 1'b0;
        check("rst mid req_ready", req_ready, 1);
        check("rst mid wr_ready", wr_ready, 0);
        check("rst mid resp", resp_valid, 0);
        check("rst mid rd_data", rd_data, 8'h00);
        tick();
        check("rst mid no resp later", resp_valid, 0);
        $display("[TB] mid-write reset done");
        read_burst("rst rd", 8'h20, 2'd3, 32'h00000011);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
